// File: rtl/conv_stream_pkg.sv
// Shared types and elaboration-time helpers for the activation streamer.
package conv_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    // Border padding on each side of a window; the kernel is always odd.
    function automatic int pad_offset(input int k);
        return k / 2;
    endfunction

    // Width of a loop counter that runs 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Signed coordinate width with room for the negative padding offsets.
    function automatic int coord_width(input int w, input int h);
        return $clog2((w > h) ? w : h) + 2;
    endfunction

    // Words emitted by one full feature-map pass.
    function automatic int total_words(input int w, input int h, input int c, input int k);
        return w * h * k * k * c;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output FIFO carrying an activation word and its end-of-pass tag.
module stream_fifo2 #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  arst_in,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last
);

    logic [DATA_WIDTH-1:0] data_q [2];
    logic                  last_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q[0] <= 1'b0;
            last_q[1] <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_ptr_q] <= push_data;
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign count     = count_q;
    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];

endmodule

// File: rtl/conv_act_streamer.sv
// Streams the feature map from external memory as im2col windows with zero padding.
module conv_act_streamer #(
    parameter int unsigned DATA_WIDTH         = 16,
    parameter int unsigned EXT_MEM_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH         = 20,
    parameter int unsigned FEATURE_MAP_WIDTH  = 128,
    parameter int unsigned FEATURE_MAP_HEIGHT = 128,
    parameter int unsigned INPUT_NB_CHANNELS  = 2,
    parameter int unsigned KERNEL_SIZE        = 3
) (
    input  logic                     clk,
    input  logic                     arst_in,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_re,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [EXT_MEM_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0]    a_input,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic                     a_last
);

    import conv_stream_pkg::*;

    localparam int XW  = cnt_width(FEATURE_MAP_WIDTH);
    localparam int YW  = cnt_width(FEATURE_MAP_HEIGHT);
    localparam int KW  = cnt_width(KERNEL_SIZE);
    localparam int CHW = cnt_width(INPUT_NB_CHANNELS);
    localparam int CW  = coord_width(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT);
    localparam int PAD = pad_offset(KERNEL_SIZE);

    localparam logic [XW-1:0]  X_MAX  = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0]  Y_MAX  = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL_SIZE - 1);
    localparam logic [CHW-1:0] CH_MAX = CHW'(INPUT_NB_CHANNELS - 1);

    localparam logic signed [CW-1:0] W_S   = CW'(FEATURE_MAP_WIDTH);
    localparam logic signed [CW-1:0] H_S   = CW'(FEATURE_MAP_HEIGHT);
    localparam logic signed [CW-1:0] PAD_S = CW'(PAD);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [YW-1:0]         y_q;
    logic [XW-1:0]         x_q;
    logic [KW-1:0]         ky_q;
    logic [KW-1:0]         kx_q;
    logic [CHW-1:0]        ch_q;
    logic                  done_q;

    // One-deep issue pipeline: a slot in flight, whether it is padding, and the end tag.
    logic                  inflight_q;
    logic                  pad_q;
    logic                  tag_last_q;

    logic [1:0]            fifo_count;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] push_data;

    logic                  pop;
    logic                  allow;
    logic                  issue;
    logic                  last_elem;
    logic                  drain_ok;
    logic signed [CW-1:0]  iy;
    logic signed [CW-1:0]  ix;
    logic                  in_bounds;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  unused_rdata;

    assign unused_rdata = ^mem_rdata[EXT_MEM_WIDTH-1:DATA_WIDTH];

    assign pop   = a_valid && a_ready;
    // Occupancy after this cycle's pop must leave room for the slot issued now.
    assign allow = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign issue = (state_q == RUN) && allow;

    assign last_elem = (y_q == Y_MAX) && (x_q == X_MAX) && (ky_q == K_MAX) &&
                       (kx_q == K_MAX) && (ch_q == CH_MAX);

    // Nothing left once the FIFO empties this cycle with no slot in flight.
    assign drain_ok = !inflight_q &&
                      ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    // Window coordinates, border test and wrapped word address of the current slot.
    always_comb begin
        iy = $signed(CW'(y_q)) + $signed(CW'(ky_q)) - PAD_S;
        ix = $signed(CW'(x_q)) + $signed(CW'(kx_q)) - PAD_S;
        in_bounds = !iy[CW-1] && (iy < H_S) && !ix[CW-1] && (ix < W_S);
        word_addr = base_q
                  + ADDR_WIDTH'($unsigned(iy)) * ADDR_WIDTH'(FEATURE_MAP_WIDTH)
                    * ADDR_WIDTH'(INPUT_NB_CHANNELS)
                  + ADDR_WIDTH'($unsigned(ix)) * ADDR_WIDTH'(INPUT_NB_CHANNELS)
                  + ADDR_WIDTH'(ch_q);
    end

    assign mem_re   = issue && in_bounds;
    assign mem_addr = mem_re ? word_addr : '0;

    // FSM, loop counters and the registered done pulse.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q <= IDLE;
            base_q  <= '0;
            y_q     <= '0;
            x_q     <= '0;
            ky_q    <= '0;
            kx_q    <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        y_q     <= '0;
                        x_q     <= '0;
                        ky_q    <= '0;
                        kx_q    <= '0;
                        ch_q    <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (ch_q != CH_MAX) begin
                            ch_q <= ch_q + 1'b1;
                        end else begin
                            ch_q <= '0;
                            if (kx_q != K_MAX) begin
                                kx_q <= kx_q + 1'b1;
                            end else begin
                                kx_q <= '0;
                                if (ky_q != K_MAX) begin
                                    ky_q <= ky_q + 1'b1;
                                end else begin
                                    ky_q <= '0;
                                    if (x_q != X_MAX) begin
                                        x_q <= x_q + 1'b1;
                                    end else begin
                                        x_q <= '0;
                                        y_q <= (y_q == Y_MAX) ? '0 : y_q + 1'b1;
                                    end
                                end
                            end
                        end
                        if (last_elem) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_ok) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Track the slot issued last cycle so its data (or zero) lands in the FIFO in order.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            inflight_q <= 1'b0;
            pad_q      <= 1'b0;
            tag_last_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            pad_q      <= issue && !in_bounds;
            tag_last_q <= issue && last_elem;
        end
    end

    assign push_data = pad_q ? '0 : mem_rdata[DATA_WIDTH-1:0];

    stream_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .arst_in   (arst_in),
        .push      (inflight_q),
        .push_data (push_data),
        .push_last (tag_last_q),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign a_valid = (fifo_count != 2'd0);
    assign a_input = head_data;
    assign a_last  = a_valid && head_last;

endmodule
